// File: rtl/line_deserializer.sv
// ---------------------------------------------------------------------------
// line_deserializer
//   Memory-side cache fill stage. Collects WORDS consecutive WORD_W-bit words
//   from the memory read channel and presents them as one cache line. The
//   first word accepted lands in the lowest slot (bits [WORD_W-1:0]), which
//   matches the emit order of the companion write serializer.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort, drops any partial or held line
//   in_valid   memory word valid
//   in_data    memory word
//   in_ready   block accepts a word this cycle (decoded from state only)
//   out_valid  assembled line available
//   out_data   assembled line, word k at [k*WORD_W +: WORD_W]
//   out_ready  cache accepts the line
//   word_cnt   words captured into the current line (0..WORDS)
//   busy       FSM is not idle
// ---------------------------------------------------------------------------
module line_deserializer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [WORD_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WORD_W*WORDS-1:0]   out_data,
    input  logic                      out_ready,
    output logic [$clog2(WORDS):0]    word_cnt,
    output logic                      busy
);

    localparam int IDX_W  = $clog2(WORDS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int LINE_W = WORD_W * WORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic                load_s;
    logic [LINE_W-1:0]   line_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic [IDX_W-1:0]    slot_s;

    // The slot being written is the low bits of the current word count.
    assign slot_s = cnt_r[IDX_W-1:0];

    // Next-state and word-capture decision; clear overrides every other event.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        if (clear) begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        load_s  = 1'b1;
                        cnt_s   = cnt_r + CNT_W'(1);
                        state_s = ST_FILL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        load_s = 1'b1;
                        cnt_s  = cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(WORDS - 1)) begin
                            state_s = ST_FULL;
                        end else begin
                            state_s = ST_FILL;
                        end
                    end else begin
                        state_s = ST_FILL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_valid is ignored.
                    if (out_ready) begin
                        state_s = ST_IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, count and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= (state_s != ST_FULL);
            out_valid_r <= (state_s == ST_FULL);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Line storage: only the addressed slot is written, nothing shifts, and
    // clear leaves the stored line untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= {LINE_W{1'b0}};
        end else if (load_s) begin
            line_r[slot_s*WORD_W +: WORD_W] <= in_data;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = line_r;
    assign word_cnt  = cnt_r;
    assign busy      = busy_r;

endmodule

// File: doc/line_deserializer.md
Name: line_deserializer

Overview:
- Memory-side fill stage for the cache. Collects eight consecutive 32-bit words from the memory read channel and assembles them into one 256-bit cache line for the cache data array.
- Mirror of the 256-to-32 write serializer. Word 0, the first word accepted, lands in line bits [31:0], which matches the serializer's emit order.
- Valid/ready handshakes on both the word side and the line side.

Parameters:
- WORD_W, 32, width of one memory word.
- WORDS, 8, words per line; a power of two ≥ 2. Line width is WORD_W*WORDS.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards any partial or held line.
- in_valid  input  1  memory word valid.
- in_data  input  WORD_W  memory word.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  assembled line available.
- out_data  output  WORD_W*WORDS  assembled line; word k is at bits [k*WORD_W +: WORD_W].
- out_ready  input  1  cache is accepting the line.
- word_cnt  output  $clog2(WORDS)+1  number of words captured into the current line.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous deassert at the next clk edge):
  - FSM goes to IDLE.
  - out_valid=0, out_data=0, word_cnt=0, busy=0.
  - Any partial line is lost, including one caught mid-fill.
- Word accept:
  - A word is accepted only on a clock edge where in_valid && in_ready.
  - The accepted word is written to slot word_cnt, then word_cnt increments by 1.
  - Slots not yet written keep their previous contents. Words are never shifted.
- FSM states:
  - IDLE: in_ready=1, busy=0. Accepting a word moves to FILL with word_cnt=1.
  - FILL: in_ready=1, busy=1. Accepting a word while word_cnt==WORDS-1 moves to FULL with word_cnt=WORDS; otherwise stay in FILL.
  - FULL: in_ready=0, out_valid=1, busy=1. out_valid and out_data are held stable until the edge where out_ready=1. On that edge: go to IDLE, word_cnt=0, out_valid=0. out_data keeps its last value and is don't-care once out_valid=0.
- Latency:
  - out_valid rises on the clock edge that accepts the WORDS-th word.
  - Minimum of WORDS cycles from the first word to out_valid.
  - Minimum of WORDS+1 cycles per line, because of the one-cycle gap for the FULL→IDLE handoff.
- Backpressure:
  - in_ready is driven purely from FSM state, with no combinational path from out_ready.
  - in_valid may toggle between words. Bubbles are allowed and do not advance word_cnt.
- clear:
  - Takes priority over every other event in the same cycle, including a word accept and a line handoff.
  - Next state is IDLE with word_cnt=0 and out_valid=0. out_data is not cleared.
  - Any word presented in the clear cycle is dropped, although in_ready still reflects the current state.
- Simultaneous events:
  - In FULL, in_valid=1 is ignored because in_ready=0.
  - out_ready is ignored in IDLE and FILL.
- Arithmetic:
  - word_cnt never exceeds WORDS and never wraps.
  - Reaching WORDS is the only route into FULL.
- Protocol violation: if in_data changes while in_valid=1 && in_ready=0, nothing is captured. No assertion is required in RTL.

Test Plan:
- Back-to-back fill: apply reset, then send words 0x11111111..0x88888888 on 8 consecutive cycles with out_ready=1.
  - out_valid rises on edge 8.
  - out_data=0x88888888_77777777_..._11111111.
  - Next cycle: IDLE, word_cnt=0.
- Backpressure: complete a line with out_ready=0 for 5 cycles while in_valid=1 with new data.
  - in_ready=0 and out_data is unchanged throughout.
  - Handoff occurs on the first out_ready=1 edge.
  - A second line of 0xA0..0xA7 then assembles correctly.
- Bubbles: send 8 words with in_valid deasserted on alternate cycles.
  - word_cnt steps 0→8 on accept edges only.
  - The line is correct after 15 cycles.
- clear mid-fill: after 3 words, assert clear in the same cycle as a 4th word 0xDEADBEEF.
  - State returns to IDLE with word_cnt=0.
  - The next 8 words form a clean line containing no 0xDEADBEEF.
- clear vs handoff: assert clear and out_ready together while in FULL.
  - out_valid=0 the next cycle and word_cnt=0; the line is dropped.
- Async reset mid-fill: drop rst_n between clock edges after 5 words.
  - All outputs reach their reset values immediately, without waiting for a clock edge.
  - After release, a full line assembles normally.
